// File: rtl/gobang_pkg.sv
// Shared gobang board geometry, line-direction encoding and win-checker state type.
package gobang_pkg;

    localparam int unsigned BOARD_N  = 15;
    localparam int unsigned CELLS    = BOARD_N * BOARD_N;
    localparam int unsigned WIN_LEN  = 5;

    localparam int unsigned COORD_W  = 4;
    localparam int unsigned SCOORD_W = 5;
    localparam int unsigned IDX_W    = 8;
    localparam int unsigned K_W      = 3;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned CNT_MAX  = 2 * (WIN_LEN - 1);
    localparam int unsigned DIR_W    = 2;

    typedef enum logic [DIR_W-1:0] {
        DIR_HORZ = 2'd0,
        DIR_VERT = 2'd1,
        DIR_DIAG = 2'd2,
        DIR_ANTI = 2'd3
    } dirT;

    typedef struct packed {
        logic signed [1:0] dr;
        logic signed [1:0] dc;
    } stepT;

    // Unit step (row, col) of each scan direction
    function automatic stepT dirStep(input dirT dir);
        stepT s;
        case (dir)
            DIR_HORZ: begin s.dr = 2'sd0; s.dc =  2'sd1; end
            DIR_VERT: begin s.dr = 2'sd1; s.dc =  2'sd0; end
            DIR_DIAG: begin s.dr = 2'sd1; s.dc =  2'sd1; end
            DIR_ANTI: begin s.dr = 2'sd1; s.dc = -2'sd1; end
            default:  begin s.dr = 2'sd0; s.dc =  2'sd1; end
        endcase
        return s;
    endfunction

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        POS  = 3'd1,
        NEG  = 3'd2,
        EVAL = 3'd3,
        FIN  = 3'd4
    } stateT;

endpackage

// File: rtl/board_coord_step.sv
// Combinational neighbour lookup: cell k steps from (row, col) along dir,
// forwards or backwards, with an on-board flag (no wrap across rows).
module board_coord_step
    import gobang_pkg::*;
(
    input  logic [COORD_W-1:0] row,
    input  logic [COORD_W-1:0] col,
    input  logic [K_W-1:0]     k,
    input  logic [DIR_W-1:0]   dir,
    input  logic               sign,
    output logic [IDX_W-1:0]   cellIdx,
    output logic               onBoard
);

    stepT                       step;
    logic signed [SCOORD_W-1:0] kS;
    logic signed [SCOORD_W-1:0] drS;
    logic signed [SCOORD_W-1:0] dcS;
    logic signed [SCOORD_W-1:0] offR;
    logic signed [SCOORD_W-1:0] offC;
    logic signed [SCOORD_W-1:0] r;
    logic signed [SCOORD_W-1:0] c;
    logic                       rOk;
    logic                       cOk;

    // Overflow past 15 lands negative in 5 bits, so it still reads as off-board
    always_comb begin
        step = dirStep(dirT'(dir));
        kS   = signed'(SCOORD_W'(k));
        drS  = signed'({{(SCOORD_W-2){step.dr[1]}}, step.dr});
        dcS  = signed'({{(SCOORD_W-2){step.dc[1]}}, step.dc});
        offR = drS * kS;
        offC = dcS * kS;
        if (sign) begin
            r = signed'(SCOORD_W'(row)) - offR;
            c = signed'(SCOORD_W'(col)) - offC;
        end else begin
            r = signed'(SCOORD_W'(row)) + offR;
            c = signed'(SCOORD_W'(col)) + offC;
        end
        rOk     = !r[SCOORD_W-1] && (r[COORD_W-1:0] < COORD_W'(BOARD_N));
        cOk     = !c[SCOORD_W-1] && (c[COORD_W-1:0] < COORD_W'(BOARD_N));
        onBoard = rOk && cOk;
        cellIdx = onBoard ? (IDX_W'(r[COORD_W-1:0]) * IDX_W'(BOARD_N) + IDX_W'(c[COORD_W-1:0]))
                          : '0;
    end

endmodule

// File: rtl/win_checker.sv
// Five-in-a-row detector: walks the four lines through the just-placed stone,
// one cell per clock, and reports win/direction or a malformed request.
module win_checker
    import gobang_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [CELLS-1:0]   board,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic               busy,
    output logic               done,
    output logic               win,
    output logic [DIR_W-1:0]   win_dir,
    output logic               err
);

    localparam logic [K_W-1:0]   K_FIRST = K_W'(1);
    localparam logic [K_W-1:0]   K_LAST  = K_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] RUN_WIN = CNT_W'(WIN_LEN);

    stateT              state;
    stateT              nextState;
    logic [CELLS-1:0]   boardReg;
    logic [CELLS-1:0]   boardNext;
    logic [COORD_W-1:0] xReg;
    logic [COORD_W-1:0] xNext;
    logic [COORD_W-1:0] yReg;
    logic [COORD_W-1:0] yNext;
    logic [DIR_W-1:0]   dirReg;
    logic [DIR_W-1:0]   dirNext;
    logic [CNT_W-1:0]   countReg;
    logic [CNT_W-1:0]   countNext;
    logic [K_W-1:0]     kReg;
    logic [K_W-1:0]     kNext;
    logic               busyNext;
    logic               doneNext;
    logic               winNext;
    logic [DIR_W-1:0]   winDirNext;
    logic               errNext;

    logic [IDX_W-1:0]   scanIdx;
    logic               scanOn;
    logic [IDX_W-1:0]   centreIdx;
    logic               centreOn;
    logic               stoneHit;
    logic               badReq;
    logic [CNT_W-1:0]   countInc;
    logic [CNT_W-1:0]   run;

    board_coord_step uScan (
        .row     (xReg),
        .col     (yReg),
        .k       (kReg),
        .dir     (dirReg),
        .sign    (state == NEG),
        .cellIdx (scanIdx),
        .onBoard (scanOn)
    );

    // k=0 lookup yields the placed cell itself plus its range check
    board_coord_step uCentre (
        .row     (xReg),
        .col     (yReg),
        .k       ('0),
        .dir     ('0),
        .sign    (1'b0),
        .cellIdx (centreIdx),
        .onBoard (centreOn)
    );

    always_comb begin
        stoneHit = scanOn && boardReg[scanIdx];
        badReq   = !centreOn || !boardReg[centreIdx];
        countInc = (countReg >= CNT_SAT) ? countReg : countReg + CNT_W'(1);
        run      = countReg + CNT_W'(1);
    end

    // Next-state and next-output logic
    always_comb begin
        nextState  = state;
        boardNext  = boardReg;
        xNext      = xReg;
        yNext      = yReg;
        dirNext    = dirReg;
        countNext  = countReg;
        kNext      = kReg;
        busyNext   = busy;
        doneNext   = 1'b0;
        winNext    = win;
        winDirNext = win_dir;
        errNext    = err;

        case (state)
            IDLE: begin
                if (start) begin
                    boardNext  = board;
                    xNext      = x;
                    yNext      = y;
                    busyNext   = 1'b1;
                    winNext    = 1'b0;
                    errNext    = 1'b0;
                    winDirNext = '0;
                    dirNext    = '0;
                    countNext  = '0;
                    kNext      = K_FIRST;
                    nextState  = POS;
                end
            end

            // The request is validated on the captured copy, so a bad request
            // spends one POS cycle before finishing.
            POS: begin
                if (badReq) begin
                    errNext   = 1'b1;
                    busyNext  = 1'b0;
                    doneNext  = 1'b1;
                    nextState = FIN;
                end else if (stoneHit) begin
                    countNext = countInc;
                    if (kReg == K_LAST) begin
                        kNext     = K_FIRST;
                        nextState = NEG;
                    end else begin
                        kNext = kReg + K_W'(1);
                    end
                end else begin
                    kNext     = K_FIRST;
                    nextState = NEG;
                end
            end

            NEG: begin
                if (stoneHit) begin
                    countNext = countInc;
                    if (kReg == K_LAST) begin
                        nextState = EVAL;
                    end else begin
                        kNext = kReg + K_W'(1);
                    end
                end else begin
                    nextState = EVAL;
                end
            end

            EVAL: begin
                if (run >= RUN_WIN) begin
                    winNext    = 1'b1;
                    winDirNext = dirReg;
                    busyNext   = 1'b0;
                    doneNext   = 1'b1;
                    nextState  = FIN;
                end else if (dirT'(dirReg) == DIR_ANTI) begin
                    busyNext  = 1'b0;
                    doneNext  = 1'b1;
                    nextState = FIN;
                end else begin
                    dirNext   = dirReg + DIR_W'(1);
                    countNext = '0;
                    kNext     = K_FIRST;
                    nextState = POS;
                end
            end

            FIN: begin
                nextState = IDLE;
            end

            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            boardReg <= '0;
            xReg     <= '0;
            yReg     <= '0;
            dirReg   <= '0;
            countReg <= '0;
            kReg     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            win      <= 1'b0;
            win_dir  <= '0;
            err      <= 1'b0;
        end else begin
            state    <= nextState;
            boardReg <= boardNext;
            xReg     <= xNext;
            yReg     <= yNext;
            dirReg   <= dirNext;
            countReg <= countNext;
            kReg     <= kNext;
            busy     <= busyNext;
            done     <= doneNext;
            win      <= winNext;
            win_dir  <= winDirNext;
            err      <= errNext;
        end
    end

endmodule

// File: tb/tb_win_checker.sv
// Scoreboard bench for win_checker: directed boards with hand-derived results.
module tb_win_checker;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [224:0] board = '0;
    logic [3:0]   x = '0;
    logic [3:0]   y = '0;
    logic         busy;
    logic         done;
    logic         win;
    logic [1:0]   win_dir;
    logic         err;

    always #5 clk = ~clk;

    win_checker dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .board   (board),
        .x       (x),
        .y       (y),
        .busy    (busy),
        .done    (done),
        .win     (win),
        .win_dir (win_dir),
        .err     (err)
    );

    typedef struct {
        logic       win;
        logic [1:0] dir;
        logic       err;
        int         lat;
        string      name;
    } expT;

    expT          sbQ[$];
    int           vectors = 0;
    int           miscompares = 0;
    int           edgeCnt = 0;
    int           startEdge = 0;
    logic [224:0] bb;

    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [224:0] stone(input logic [224:0] b, input int r, input int c);
        logic [224:0] t;
        t = b;
        t[r*15 + c] = 1'b1;
        return t;
    endfunction

    // Monitor: every done pulse is matched against the oldest expectation
    always @(negedge clk) begin
        expT e;
        if (!reset && done) begin
            if (sbQ.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sbQ.pop_front();
                check({e.name, "_win"}, int'(win), int'(e.win));
                check({e.name, "_dir"}, int'(win_dir), int'(e.dir));
                check({e.name, "_err"}, int'(err), int'(e.err));
                check({e.name, "_latency"}, edgeCnt - startEdge + 1, e.lat);
            end
        end
    end

    task automatic runCheck(input string name, input logic [224:0] b, input int r, input int c,
                            input logic eWin, input int eDir, input logic eErr, input int eLat,
                            input int injectAt);
        int busyCnt;
        bit got;
        busyCnt = 0;
        got = 1'b0;
        sbQ.push_back('{eWin, 2'(eDir), eErr, eLat, name});
        @(negedge clk);
        board = b;
        x = 4'(r);
        y = 4'(c);
        start = 1'b1;
        @(posedge clk);
        #1;
        startEdge = edgeCnt;
        start = 1'b0;
        for (int i = 1; i <= 60 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
            else if (busy) busyCnt++;
            if (i == injectAt) begin
                board = '0;
                x = '0;
                y = '0;
                start = 1'b1;
            end else if (i == injectAt + 1) begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (!got) begin
            check({name, "_timeout"}, 0, 1);
            if (sbQ.size() > 0) void'(sbQ.pop_back());
        end else begin
            check({name, "_busy_cycles"}, busyCnt, eLat - 1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit sawDone;
        repeat (3) @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_win", int'(win), 0);
        check("reset_err", int'(err), 0);
        check("reset_dir", int'(win_dir), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Isolated stone: 4 x 3 scan cycles, FIN in cycle 13
        bb = stone('0, 7, 7);
        runCheck("lone", bb, 7, 7, 1'b0, 0, 1'b0, 13, -1);

        // Horizontal five ending at the placed stone; a start mid-check is ignored
        bb = '0;
        for (int c = 3; c <= 7; c++) bb = stone(bb, 7, c);
        runCheck("horiz", bb, 7, 7, 1'b1, 0, 1'b0, 7, 3);
        repeat (8) @(negedge clk);
        check("hold_win", int'(win), 1);
        check("hold_dir", int'(win_dir), 0);
        check("hold_busy", int'(busy), 0);

        // Anti-diagonal touching the top-right corner
        bb = '0;
        bb = stone(bb, 0, 14);
        bb = stone(bb, 1, 13);
        bb = stone(bb, 2, 12);
        bb = stone(bb, 3, 11);
        bb = stone(bb, 4, 10);
        runCheck("anti", bb, 2, 12, 1'b1, 3, 1'b0, 17, -1);

        // Row 0 cols 12-14 must not join row 1 cols 0-1
        bb = '0;
        for (int c = 12; c <= 14; c++) bb = stone(bb, 0, c);
        bb = stone(bb, 1, 0);
        bb = stone(bb, 1, 1);
        runCheck("nowrap", bb, 0, 14, 1'b0, 0, 1'b0, 15, -1);

        // Vertical overline of seven
        bb = '0;
        for (int r = 2; r <= 8; r++) bb = stone(bb, r, 5);
        runCheck("vert7", bb, 5, 5, 1'b1, 1, 1'b0, 13, -1);

        // Nine on the main diagonal, count reaches 8
        bb = '0;
        for (int i = 3; i <= 11; i++) bb = stone(bb, i, i);
        runCheck("diag9", bb, 7, 7, 1'b1, 2, 1'b0, 16, -1);

        // Four at the left edge: no win, clears previous win
        bb = '0;
        for (int c = 0; c <= 3; c++) bb = stone(bb, 10, c);
        runCheck("four", bb, 10, 0, 1'b0, 0, 1'b0, 16, -1);

        // Bad requests
        bb = stone('0, 0, 0);
        runCheck("bad_x", bb, 15, 0, 1'b0, 0, 1'b1, 2, -1);
        runCheck("bad_y", bb, 0, 15, 1'b0, 0, 1'b1, 2, -1);
        bb = stone('0, 7, 7);
        runCheck("empty_cell", bb, 3, 3, 1'b0, 0, 1'b1, 2, -1);

        // Reset in cycle 5 of a check aborts with no done pulse
        @(negedge clk);
        board = stone('0, 7, 7);
        x = 4'd7;
        y = 4'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort_outputs", int'({busy, done, win, err, win_dir}), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sawDone = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done) sawDone = 1'b1;
        end
        check("abort_no_done", int'(sawDone), 0);

        bb = stone('0, 7, 7);
        runCheck("lone_after_reset", bb, 7, 7, 1'b0, 0, 1'b0, 13, -1);

        repeat (3) @(negedge clk);
        check("queue_empty", sbQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
